// File: rtl/sb_tx_arb.sv
// Sideband TX arbiter: round-robin message grant plus start-pattern priority,
// sequencing issue, busy handshake, timeout and inter-message gap toward the TX FSM.
module sb_tx_arb #(
   parameter int N_REQ   = 3,
   parameter int MSG_W   = 16,
   parameter int BUSY_TO = 15,
   parameter int GAP_CYC = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*MSG_W-1:0] i_req_msg,
   input  logic [N_REQ-1:0]       i_req_has_data,
   input  logic                   i_pattern_req,
   input  logic                   i_busy,
   input  logic                   i_start_pattern_done,
   output logic [N_REQ-1:0]       o_gnt,
   output logic [N_REQ-1:0]       o_done,
   output logic                   o_pattern_done,
   output logic                   o_msg_valid,
   output logic [MSG_W-1:0]       o_msg,
   output logic                   o_data_valid,
   output logic                   o_start_pattern_req,
   output logic                   o_err_timeout,
   output logic                   o_arb_busy
);

   localparam int CNT_MAX_VAL = (BUSY_TO > GAP_CYC) ? BUSY_TO : GAP_CYC;
   localparam int CNT_W       = (CNT_MAX_VAL < 1) ? 1 : $clog2(CNT_MAX_VAL + 1);
   localparam int PTR_W       = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX_VAL);
   localparam logic [CNT_W:0]   BUSY_LIM = (CNT_W + 1)'(BUSY_TO);
   localparam logic [CNT_W:0]   GAP_LIM  = (CNT_W + 1)'(GAP_CYC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PATTERN,
      ST_ISSUE_WAIT,
      ST_XFER,
      ST_GAP
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [PTR_W-1:0]   last_grant_reg;
   logic [N_REQ-1:0]   gnt_reg;
   logic [N_REQ-1:0]   done_reg;
   logic [MSG_W-1:0]   msg_reg;
   logic               msg_valid_reg;
   logic               data_valid_reg;
   logic               start_pat_reg;
   logic               pat_done_reg;
   logic               err_reg;

   logic [MSG_W-1:0]   msg_arr [N_REQ];
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [CNT_W:0]     cnt_inc;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_msg
      assign msg_arr[gi] = i_req_msg[gi*MSG_W +: MSG_W];
   end

   // Rotating priority: search upward starting just after the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!win_found && i_req[(int'(last_grant_reg) + i) % N_REQ]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'((int'(last_grant_reg) + i) % N_REQ);
         end
      end
   end

   // One wider so the terminal compare cannot overflow at saturation.
   assign cnt_inc = {1'b0, cnt_reg} + (CNT_W + 1)'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= PTR_W'(N_REQ - 1);
         gnt_reg        <= '0;
         done_reg       <= '0;
         msg_reg        <= '0;
         msg_valid_reg  <= 1'b0;
         data_valid_reg <= 1'b0;
         start_pat_reg  <= 1'b0;
         pat_done_reg   <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         gnt_reg        <= '0;
         done_reg       <= '0;
         msg_valid_reg  <= 1'b0;
         data_valid_reg <= 1'b0;
         start_pat_reg  <= 1'b0;
         pat_done_reg   <= 1'b0;
         err_reg        <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               cnt_reg <= '0;
               if (i_pattern_req) begin
                  start_pat_reg <= 1'b1;
                  state_reg     <= ST_PATTERN;
               end else if (win_found) begin
                  gnt_reg        <= N_REQ'(1) << win_idx;
                  msg_valid_reg  <= 1'b1;
                  data_valid_reg <= i_req_has_data[win_idx];
                  msg_reg        <= msg_arr[win_idx];
                  last_grant_reg <= win_idx;
                  state_reg      <= ST_ISSUE_WAIT;
               end
            end
            ST_PATTERN: begin
               if (i_start_pattern_done) begin
                  pat_done_reg <= 1'b1;
                  cnt_reg      <= '0;
                  state_reg    <= ST_GAP;
               end
            end
            ST_ISSUE_WAIT: begin
               if (i_busy) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_XFER;
               end else if (cnt_inc >= BUSY_LIM) begin
                  err_reg   <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= ST_GAP;
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_XFER: begin
               if (!i_busy) begin
                  done_reg  <= N_REQ'(1) << last_grant_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_inc >= GAP_LIM) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else if (cnt_reg != CNT_SAT) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               cnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_gnt               = gnt_reg;
   assign o_done              = done_reg;
   assign o_msg               = msg_reg;
   assign o_msg_valid         = msg_valid_reg;
   assign o_data_valid        = data_valid_reg;
   assign o_start_pattern_req = start_pat_reg;
   assign o_pattern_done      = pat_done_reg;
   assign o_err_timeout       = err_reg;
   assign o_arb_busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_arb.sv
// Directed bench for sb_tx_arb: round-robin order, pattern priority, busy timeout,
// descriptor/data qualification and reset mid-transfer.
module tb_sb_tx_arb;
   localparam int N_REQ   = 3;
   localparam int MSG_W   = 16;
   localparam int BUSY_TO = 15;
   localparam int GAP_CYC = 4;

   logic                   clk = 1'b0;
   logic                   i_rst;
   logic [N_REQ-1:0]       i_req;
   logic [N_REQ*MSG_W-1:0] i_req_msg;
   logic [N_REQ-1:0]       i_req_has_data;
   logic                   i_pattern_req;
   logic                   i_busy;
   logic                   i_start_pattern_done;
   logic [N_REQ-1:0]       o_gnt;
   logic [N_REQ-1:0]       o_done;
   logic                   o_pattern_done;
   logic                   o_msg_valid;
   logic [MSG_W-1:0]       o_msg;
   logic                   o_data_valid;
   logic                   o_start_pattern_req;
   logic                   o_err_timeout;
   logic                   o_arb_busy;

   int cyc = 0;
   int n_checks = 0;
   int n_fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sb_tx_arb #(
      .N_REQ(N_REQ), .MSG_W(MSG_W), .BUSY_TO(BUSY_TO), .GAP_CYC(GAP_CYC)
   ) dut (
      .i_clk               (clk),
      .i_rst               (i_rst),
      .i_req               (i_req),
      .i_req_msg           (i_req_msg),
      .i_req_has_data      (i_req_has_data),
      .i_pattern_req       (i_pattern_req),
      .i_busy              (i_busy),
      .i_start_pattern_done(i_start_pattern_done),
      .o_gnt               (o_gnt),
      .o_done              (o_done),
      .o_pattern_done      (o_pattern_done),
      .o_msg_valid         (o_msg_valid),
      .o_msg               (o_msg),
      .o_data_valid        (o_data_valid),
      .o_start_pattern_req (o_start_pattern_req),
      .o_err_timeout       (o_err_timeout),
      .o_arb_busy          (o_arb_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   function automatic logic sig_sel(input int sel);
      case (sel)
         0:       return |o_gnt;
         1:       return |o_done;
         2:       return o_start_pattern_req;
         3:       return o_pattern_done;
         default: return o_err_timeout;
      endcase
   endfunction

   // Waits (bounded) for a selected pulse; an expired bound counts as a failure.
   task automatic wait_for(input int sel, input int budget, input string tag, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sig_sel(sel)) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) check_val({tag, "_expired"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!o_arb_busy) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) check_val({tag, "_idle_expired"}, 32'd0, 32'd1);
   endtask

   initial begin
      int g_cyc, d_cyc, s_cyc, pd_cyc, e_cyc, prev_done, msg_bad, done_seen, k;
      logic [N_REQ-1:0] done_val;
      int          exp_order [4] = '{0, 1, 2, 0};
      logic [15:0] exp_msg   [3] = '{16'h1000, 16'h2001, 16'h3002};
      logic        exp_dv    [3] = '{1'b1, 1'b0, 1'b1};

      i_rst = 1'b1; i_req = '0; i_req_msg = '0; i_req_has_data = '0;
      i_pattern_req = 1'b0; i_busy = 1'b0; i_start_pattern_done = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_pulses", {o_gnt, o_done, o_msg_valid, o_data_valid,
                               o_start_pattern_req, o_pattern_done, o_err_timeout}, 32'd0);
      check_val("rst_msg", o_msg, 32'd0);
      check_val("rst_arb_busy", o_arb_busy, 32'd0);
      i_rst = 1'b0;

      // Round-robin with all three requesting: 0,1,2,0 and 4 gap cycles between
      i_req_msg      = {16'h3002, 16'h2001, 16'h1000};
      i_req_has_data = 3'b101;
      i_req          = 3'b111;
      prev_done = -1;
      for (int t = 0; t < 4; t++) begin
         wait_for(0, 30, "rr_gnt", g_cyc);
         k = exp_order[t];
         check_val("rr_gnt", o_gnt, 32'd1 << k);
         check_val("rr_msg_valid", o_msg_valid, 32'd1);
         check_val("rr_msg", o_msg, exp_msg[k]);
         check_val("rr_data_valid", o_data_valid, exp_dv[k]);
         if (t > 0) check_val("rr_gap", g_cyc - prev_done, 32'd5);
         if (t == 3) i_req = '0;
         i_busy = 1'b1;
         repeat (3) @(negedge clk);
         i_busy = 1'b0;
         wait_for(1, 10, "rr_done", d_cyc);
         check_val("rr_done", o_done, 32'd1 << k);
         prev_done = d_cyc;
         @(negedge clk);
         check_val("rr_done_pulse", o_done, 32'd0);
      end
      wait_idle("rr");

      // Pattern beats a simultaneous message request; pointer stays at 0 so requester 1 wins
      i_req_msg      = {16'h3002, 16'hA5C3, 16'h1000};
      i_req_has_data = 3'b010;
      i_req          = 3'b110;
      i_pattern_req  = 1'b1;
      wait_for(2, 5, "pat_start", s_cyc);
      check_val("pat_no_gnt", o_gnt, 32'd0);
      check_val("pat_arb_busy", o_arb_busy, 32'd1);
      i_pattern_req = 1'b0;
      @(negedge clk);
      check_val("pat_start_pulse", o_start_pattern_req, 32'd0);
      repeat (2) @(negedge clk);
      check_val("pat_wait_quiet", {o_pattern_done, o_gnt}, 32'd0);
      i_start_pattern_done = 1'b1;
      wait_for(3, 5, "pat_done", pd_cyc);
      i_start_pattern_done = 1'b0;
      wait_for(0, 12, "pat_gnt", g_cyc);
      check_val("pat_gnt", o_gnt, 32'b010);
      check_val("pat_gap", g_cyc - pd_cyc, 32'd5);
      check_val("pat_msg", o_msg, 32'hA5C3);
      check_val("pat_data_valid", {o_msg_valid, o_data_valid}, 32'b11);
      i_req = '0;
      msg_bad = 0;
      done_val = '0;
      i_busy = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (o_msg !== 16'hA5C3) msg_bad++;
      end
      i_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (o_done != 0) done_val = o_done;
         if (!o_arb_busy) break;
         if (o_msg !== 16'hA5C3) msg_bad++;
      end
      check_val("msg_stable", msg_bad, 32'd0);
      check_val("pat_xfer_done", done_val, 32'b010);
      check_val("pat_xfer_idle", o_arb_busy, 32'd0);

      // Busy timeout for requester 2 (pointer at 1, so 2 wins over 0)
      i_req = 3'b101;
      wait_for(0, 5, "to_gnt", g_cyc);
      check_val("to_gnt", o_gnt, 32'b100);
      i_req = '0;
      e_cyc = -1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_done != 0) done_seen = 1;
         if (o_err_timeout) begin
            e_cyc = cyc;
            break;
         end
      end
      check_val("to_latency", e_cyc - g_cyc, 32'd15);
      check_val("to_no_done", done_seen, 32'd0);
      @(negedge clk);
      check_val("to_err_pulse", o_err_timeout, 32'd0);
      repeat (2) @(negedge clk);
      check_val("to_gap_busy", o_arb_busy, 32'd1);
      @(negedge clk);
      check_val("to_back_idle", o_arb_busy, 32'd0);

      // Reset during XFER abandons the transfer and restores the pointer
      i_req = 3'b001;
      wait_for(0, 5, "rx_gnt", g_cyc);
      check_val("rx_gnt", o_gnt, 32'b001);
      i_req  = '0;
      i_busy = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rx_in_xfer", o_arb_busy, 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      check_val("rx_pulses", {o_gnt, o_done, o_msg_valid, o_data_valid,
                              o_start_pattern_req, o_pattern_done, o_err_timeout}, 32'd0);
      check_val("rx_msg", o_msg, 32'd0);
      check_val("rx_arb_busy", o_arb_busy, 32'd0);
      i_rst  = 1'b0;
      i_busy = 1'b0;
      done_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_done != 0 || o_err_timeout) done_seen = 1;
      end
      check_val("rx_no_done_err", done_seen, 32'd0);
      i_req = 3'b011;
      wait_for(0, 5, "rx_next_gnt", g_cyc);
      check_val("rx_next_gnt", o_gnt, 32'b001);
      i_req = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sb_tx_arb.md
SB_TX_ARB -- requirements
Module: sb_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of sideband message requesters (2..8).
REQ-002 SHALL have parameter MSG_W, default 16, width of the message descriptor per requester.
REQ-003 SHALL have parameter BUSY_TO, default 15, maximum cycles allowed between issue and i_busy rising.
REQ-004 SHALL have parameter GAP_CYC, default 4, minimum idle cycles between consecutive issues.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, the reset; it is synchronous and active-high.
REQ-007 SHALL have port i_req, input, N_REQ, level message request per requester, held until its o_gnt.
REQ-008 SHALL have port i_req_msg, input, N_REQ*MSG_W, packed descriptors; requester k uses bits [k*MSG_W +: MSG_W].
REQ-009 SHALL have port i_req_has_data, input, N_REQ, indicating the requester's message carries a data payload.
REQ-010 SHALL have port i_pattern_req, input, 1, level request for start-pattern transmission.
REQ-011 SHALL have port i_busy, input, 1, TX FSM busy.
REQ-012 SHALL have port i_start_pattern_done, input, 1, pattern-complete pulse from the pattern generator.
REQ-013 SHALL have port o_gnt, output, N_REQ, one-hot one-cycle grant pulse.
REQ-014 SHALL have port o_done, output, N_REQ, one-hot one-cycle completion pulse.
REQ-015 SHALL have port o_pattern_done, output, 1, one-cycle pattern completion pulse.
REQ-016 SHALL have port o_msg_valid, output, 1, one-cycle message-issue pulse to the TX FSM.
REQ-017 SHALL have port o_msg, output, MSG_W, granted descriptor, held stable from issue until return to IDLE.
REQ-018 SHALL have port o_data_valid, output, 1, copy of the granted i_req_has_data, qualified with o_msg_valid.
REQ-019 SHALL have port o_start_pattern_req, output, 1, one-cycle pattern-start pulse to the TX FSM.
REQ-020 SHALL have port o_err_timeout, output, 1, one-cycle pulse on busy timeout.
REQ-021 SHALL have port o_arb_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-022 SHALL implement states IDLE, PATTERN, ISSUE_WAIT, XFER, GAP.
REQ-023 IDLE: if i_pattern_req=1, the block SHALL go to PATTERN and pulse o_start_pattern_req in the same registered cycle as the transition; pattern has priority over all messages.
REQ-024 IDLE with no pattern request and any i_req bit set: round-robin winner = first set bit searching upward from (last_grant+1) mod N_REQ.
REQ-025 On winning, the block SHALL pulse o_gnt[k], o_msg_valid and o_data_valid (=i_req_has_data[k]), latch o_msg, update last_grant=k, and go to ISSUE_WAIT (all outputs registered, one cycle after the IDLE decision).
REQ-026 PATTERN -> GAP on i_start_pattern_done=1, pulsing o_pattern_done; no timeout applies in PATTERN.
REQ-027 ISSUE_WAIT: the block SHALL count cycles; on i_busy=1 -> XFER; if count reaches BUSY_TO with i_busy=0, it SHALL pulse o_err_timeout, skip o_done, and go to GAP.
REQ-028 XFER -> GAP on i_busy=0, pulsing o_done[last_grant].
REQ-029 GAP SHALL last exactly GAP_CYC cycles, then go to IDLE; no grant or pattern start is issued during GAP.
REQ-030 Requests that deassert before grant SHALL be dropped with no o_gnt; a request arriving during a non-IDLE state waits.
REQ-031 Simultaneous i_pattern_req and i_req in IDLE: pattern SHALL win; the round-robin pointer is unchanged.
REQ-032 o_gnt, o_done, o_msg_valid, o_start_pattern_req, o_pattern_done and o_err_timeout SHALL never be high for more than one consecutive cycle.
REQ-033 The counters SHALL be sized ceil(log2(max(BUSY_TO,GAP_CYC)+1)) and SHALL saturate, never wrap.

Reset
REQ-034 With i_rst=1 at a clock edge, the block SHALL go to IDLE, clear all pulse outputs, o_msg=0, o_arb_busy=0, last_grant=N_REQ-1 (requester 0 wins first), counters=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer without o_done or o_err_timeout.

Verification
REQ-036 Reset, then i_req=3'b111 held, each transfer with i_busy high 3 cycles -> grant order 0,1,2,0 with GAP_CYC=4 idle cycles between transfers.
REQ-037 i_pattern_req=1 and i_req=3'b010 in the same cycle -> o_start_pattern_req first; after i_start_pattern_done, o_pattern_done then 4 gap cycles, then o_gnt=3'b010.
REQ-038 Grant requester 2 with i_busy held 0 -> o_err_timeout after 15 cycles in ISSUE_WAIT, no o_done, then return to IDLE after GAP.
REQ-039 Requester 1 with i_req_has_data[1]=1 and descriptor 16'hA5C3 -> o_msg=16'hA5C3 and o_data_valid=1 coincident with o_msg_valid; o_msg stable until IDLE.
REQ-040 Assert i_rst during XFER -> next cycle IDLE, all outputs 0, and the next grant goes to requester 0.
